// File: rtl/decode_stage_if.sv
// Handshake and decoded-bundle bus between fetch, the decode stage and execute.
// The slave view belongs to decode_stage; the master view is the surrounding
// fetch/execute logic (or a bench) driving inst_*/out_ready and reading results.
interface decode_stage_if #(
    parameter int REG_AW = 5,
    parameter int IMM_W  = 8,
    parameter int RAM_AW = 16,
    parameter int CNT_W  = 16
);
    logic [31:0]       inst_i;
    logic              inst_valid_i;
    logic              inst_ready_o;
    logic              flush_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [7:0]        alu_o;
    logic [1:0]        pc_o;
    logic [1:0]        reg_o;
    logic              imm_o;
    logic              mem_o;
    logic [REG_AW-1:0] reg_addr_1_o;
    logic [REG_AW-1:0] reg_addr_2_o;
    logic [REG_AW-1:0] reg_addr_3_o;
    logic [REG_AW-1:0] reg_addr_4_o;
    logic [RAM_AW-1:0] ram_addr_o;
    logic [IMM_W-1:0]  imm_data_1_o;
    logic [IMM_W-1:0]  imm_data_2_o;
    logic              illegal_o;
    logic [CNT_W-1:0]  dec_count_o;

    modport slave (
        input  inst_i, inst_valid_i, flush_i, out_ready_i,
        output inst_ready_o, out_valid_o, alu_o, pc_o, reg_o, imm_o, mem_o,
               reg_addr_1_o, reg_addr_2_o, reg_addr_3_o, reg_addr_4_o,
               ram_addr_o, imm_data_1_o, imm_data_2_o, illegal_o, dec_count_o
    );

    modport master (
        output inst_i, inst_valid_i, flush_i, out_ready_i,
        input  inst_ready_o, out_valid_o, alu_o, pc_o, reg_o, imm_o, mem_o,
               reg_addr_1_o, reg_addr_2_o, reg_addr_3_o, reg_addr_4_o,
               ram_addr_o, imm_data_1_o, imm_data_2_o, illegal_o, dec_count_o
    );
endinterface

// File: rtl/decode_stage.sv
// Registered instruction decode stage. Instructions are decoded combinationally
// at push time and stored in a small FIFO; execute reads the head entry through
// a valid/ready handshake. Outputs come only from registered FIFO contents, so
// there is no combinational path from inst_i to the decoded fields.
module decode_stage #(
    parameter int BUF_DEPTH = 2,
    parameter int REG_AW    = 5,
    parameter int IMM_W     = 8,
    parameter int RAM_AW    = 16,
    parameter int CNT_W     = 16
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    decode_stage_if.slave bus
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int PW = AW + 1;

    // Opcode map (inst[31:24])
    localparam logic [7:0] OP_WAIT    = 8'd0;
    localparam logic [7:0] OP_ADD     = 8'd1;
    localparam logic [7:0] OP_SUB     = 8'd2;
    localparam logic [7:0] OP_MUL     = 8'd3;
    localparam logic [7:0] OP_DIV     = 8'd4;
    localparam logic [7:0] OP_AND     = 8'd5;
    localparam logic [7:0] OP_OR      = 8'd6;
    localparam logic [7:0] OP_NOT     = 8'd7;
    localparam logic [7:0] OP_RSHIFT  = 8'd8;
    localparam logic [7:0] OP_LSHIFT  = 8'd9;
    localparam logic [7:0] OP_MOVE    = 8'd10;
    localparam logic [7:0] OP_MOVEIN  = 8'd11;
    localparam logic [7:0] OP_MOVEOUT = 8'd12;
    localparam logic [7:0] OP_JUMP    = 8'd13;
    localparam logic [7:0] OP_EJUMP   = 8'd14;
    localparam logic [7:0] OP_NEJUMP  = 8'd15;
    localparam logic [7:0] OP_MTHAN   = 8'd16;
    localparam logic [7:0] OP_INTER   = 8'd17;

    // Dedicated architectural registers implied by some opcodes
    localparam logic [4:0] REG_INTER  = 5'd31;
    localparam logic [4:0] REG_MD_H   = 5'd30;
    localparam logic [4:0] REG_MD_L   = 5'd29;
    localparam logic [4:0] REG_JUMP_H = 5'd28;
    localparam logic [4:0] REG_JUMP_L = 5'd27;

    // Native-width decoded bundle; zero-extension happens only at the outputs
    typedef struct packed {
        logic [7:0]  alu;
        logic [1:0]  pc;
        logic [1:0]  rg;
        logic        imm;
        logic        mem;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  r3;
        logic [4:0]  r4;
        logic [15:0] ram;
        logic [7:0]  i1;
        logic [7:0]  i2;
        logic        illegal;
    } bundle_t;

    bundle_t          w_dec;
    bundle_t          w_head;
    bundle_t          r_mem [BUF_DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             r_active;
    logic [CNT_W-1:0] r_cnt;
    logic             w_full;
    logic             w_empty;
    logic             w_ready;
    logic             w_push;
    logic             w_pop;

    // Field decode of the incoming instruction; illegal encodings keep only the raw control fields
    always_comb begin
        w_dec     = '0;
        w_dec.alu = bus.inst_i[31:24];
        w_dec.pc  = bus.inst_i[23:22];
        w_dec.rg  = bus.inst_i[21:20];
        w_dec.imm = bus.inst_i[19];
        w_dec.mem = bus.inst_i[18];
        if (bus.inst_i[19]) begin
            unique case (bus.inst_i[31:24])
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_RSHIFT, OP_LSHIFT: begin
                    w_dec.r1 = bus.inst_i[9:5];
                    w_dec.r2 = bus.inst_i[4:0];
                    w_dec.i1 = bus.inst_i[17:10];
                end
                OP_NOT, OP_MOVE: begin
                    w_dec.r1 = bus.inst_i[9:5];
                    w_dec.i1 = bus.inst_i[17:10];
                end
                OP_MOVEIN: begin
                    w_dec.i1  = bus.inst_i[17:10];
                    w_dec.i2  = bus.inst_i[9:2];
                    w_dec.ram = bus.inst_i[17:2];
                end
                default: w_dec.illegal = 1'b1;
            endcase
        end else begin
            unique case (bus.inst_i[31:24])
                OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_RSHIFT, OP_LSHIFT,
                OP_MOVEOUT, OP_MTHAN: begin
                    w_dec.r1 = bus.inst_i[17:13];
                    w_dec.r2 = bus.inst_i[12:8];
                    w_dec.r3 = bus.inst_i[7:3];
                end
                OP_DIV: begin
                    w_dec.r1 = bus.inst_i[17:13];
                    w_dec.r2 = bus.inst_i[12:8];
                    w_dec.r3 = REG_MD_H;
                    w_dec.r4 = REG_MD_L;
                end
                OP_EJUMP, OP_NEJUMP: begin
                    w_dec.r1 = bus.inst_i[17:13];
                    w_dec.r2 = bus.inst_i[12:8];
                    w_dec.r3 = REG_JUMP_H;
                    w_dec.r4 = REG_JUMP_L;
                end
                OP_NOT, OP_MOVE, OP_JUMP: begin
                    w_dec.r1 = bus.inst_i[17:13];
                    w_dec.r2 = bus.inst_i[12:8];
                end
                OP_INTER: w_dec.r1 = REG_INTER;
                OP_WAIT:  ;
                default:  w_dec.illegal = 1'b1;
            endcase
        end
    end

    // FIFO status and handshakes; a full FIFO still accepts when the head leaves this cycle
    always_comb begin
        w_empty = (r_wr_ptr == r_rd_ptr);
        w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        w_pop   = !w_empty && bus.out_ready_i;
        w_ready = r_active && (!w_full || w_pop);
        w_push  = bus.inst_valid_i && w_ready && !bus.flush_i;
        w_head  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    end

    // Bundle storage; contents are never visible unless covered by the pointers
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_dec;
        end
    end

    // Pointers, post-reset enable and accepted-bundle counter; flush drops everything but the count
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_active <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_active <= 1'b1;
            if (bus.flush_i) begin
                r_rd_ptr <= r_wr_ptr;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.inst_ready_o = w_ready;
    assign bus.out_valid_o  = !w_empty;
    assign bus.alu_o        = w_head.alu;
    assign bus.pc_o         = w_head.pc;
    assign bus.reg_o        = w_head.rg;
    assign bus.imm_o        = w_head.imm;
    assign bus.mem_o        = w_head.mem;
    assign bus.reg_addr_1_o = REG_AW'(w_head.r1);
    assign bus.reg_addr_2_o = REG_AW'(w_head.r2);
    assign bus.reg_addr_3_o = REG_AW'(w_head.r3);
    assign bus.reg_addr_4_o = REG_AW'(w_head.r4);
    assign bus.ram_addr_o   = RAM_AW'(w_head.ram);
    assign bus.imm_data_1_o = IMM_W'(w_head.i1);
    assign bus.imm_data_2_o = IMM_W'(w_head.i2);
    assign bus.illegal_o    = w_head.illegal;
    assign bus.dec_count_o  = r_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus a randomized run against a
// queue-based reference model that decodes straight from the opcode rules.
module tb_decode_stage;

    localparam int DEPTH  = 2;
    localparam int REG_AW = 5;
    localparam int IMM_W  = 8;
    localparam int RAM_AW = 16;
    localparam int CNT_W  = 16;
    localparam int VW     = 8 + 2 + 2 + 1 + 1 + 4*REG_AW + RAM_AW + 2*IMM_W + 1;
    typedef logic [VW-1:0] vec_t;

    localparam logic [7:0] OP_WAIT = 8'd0, OP_ADD = 8'd1, OP_SUB = 8'd2, OP_MUL = 8'd3,
                           OP_DIV = 8'd4, OP_AND = 8'd5, OP_OR = 8'd6, OP_NOT = 8'd7,
                           OP_RSH = 8'd8, OP_LSH = 8'd9, OP_MOVE = 8'd10, OP_MOVEIN = 8'd11,
                           OP_MOVEOUT = 8'd12, OP_JUMP = 8'd13, OP_EJUMP = 8'd14,
                           OP_NEJUMP = 8'd15, OP_MTHAN = 8'd16, OP_INTER = 8'd17;
    localparam logic [4:0] REG_INTER = 5'd31, REG_MD_H = 5'd30, REG_MD_L = 5'd29,
                           REG_JUMP_H = 5'd28, REG_JUMP_L = 5'd27;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_stage_if #(.REG_AW(REG_AW), .IMM_W(IMM_W), .RAM_AW(RAM_AW), .CNT_W(CNT_W)) bus();

    decode_stage #(.BUF_DEPTH(DEPTH), .REG_AW(REG_AW), .IMM_W(IMM_W), .RAM_AW(RAM_AW),
                   .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .bus(bus)
    );

    vec_t dut_vec;
    assign dut_vec = {bus.alu_o, bus.pc_o, bus.reg_o, bus.imm_o, bus.mem_o,
                      bus.reg_addr_1_o, bus.reg_addr_2_o, bus.reg_addr_3_o, bus.reg_addr_4_o,
                      bus.ram_addr_o, bus.imm_data_1_o, bus.imm_data_2_o, bus.illegal_o};

    vec_t             q[$];
    logic [CNT_W-1:0] m_cnt = '0;
    bit               m_active = 1'b0;
    int               n_cmp = 0;
    int               n_fail = 0;

    function automatic vec_t model_decode(input logic [31:0] in);
        logic [7:0]        op;
        logic [REG_AW-1:0] r1, r2, r3, r4;
        logic [RAM_AW-1:0] ram;
        logic [IMM_W-1:0]  i1, i2;
        logic              ill;
        op = in[31:24];
        r1 = '0; r2 = '0; r3 = '0; r4 = '0; ram = '0; i1 = '0; i2 = '0;
        if (in[19]) begin
            ill = !(op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_RSH, OP_LSH,
                               OP_MOVE, OP_MOVEIN});
            if (!ill) begin
                if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_RSH, OP_LSH, OP_MOVE})
                    r1 = in[9:5];
                if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_RSH, OP_LSH})
                    r2 = in[4:0];
                i1 = in[17:10];
                if (op == OP_MOVEIN) begin
                    i2  = in[9:2];
                    ram = in[17:2];
                end
            end
        end else begin
            ill = !(op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_NOT, OP_RSH,
                               OP_LSH, OP_MOVE, OP_MOVEOUT, OP_JUMP, OP_EJUMP, OP_NEJUMP,
                               OP_MTHAN, OP_INTER, OP_WAIT});
            if (op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_NOT, OP_RSH,
                           OP_LSH, OP_MOVE, OP_MOVEOUT, OP_JUMP, OP_EJUMP, OP_NEJUMP, OP_MTHAN}) begin
                r1 = in[17:13];
                r2 = in[12:8];
            end
            if (op == OP_INTER) r1 = REG_INTER;
            if (op inside {OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_RSH, OP_LSH,
                           OP_MOVEOUT, OP_MTHAN})
                r3 = in[7:3];
            if (op == OP_DIV) begin r3 = REG_MD_H; r4 = REG_MD_L; end
            if (op inside {OP_EJUMP, OP_NEJUMP}) begin r3 = REG_JUMP_H; r4 = REG_JUMP_L; end
        end
        return {in[31:24], in[23:22], in[21:20], in[19], in[18], r1, r2, r3, r4, ram, i1, i2, ill};
    endfunction

    function automatic logic [31:0] mk(input logic [7:0] op, input logic imm, input logic [17:0] pl);
        return {op, 2'b01, 2'b10, imm, 1'b0, pl};
    endfunction

    function automatic vec_t model_head();
        return (q.size() > 0) ? q[0] : '0;
    endfunction

    function automatic bit model_ready();
        return m_active && ((q.size() < DEPTH) || (q.size() > 0 && bus.out_ready_i));
    endfunction

    task automatic apply(input logic v, input logic [31:0] in, input logic r, input logic f);
        bus.inst_valid_i = v;
        bus.inst_i       = in;
        bus.out_ready_i  = r;
        bus.flush_i      = f;
        #1;
    endtask

    // Update the model with the applied inputs, then clock the DUT
    task automatic advance();
        bit rdy;
        rdy = model_ready();
        if (rst_n) begin
            if (bus.flush_i) begin
                q.delete();
            end else begin
                if (q.size() > 0 && bus.out_ready_i) begin
                    void'(q.pop_front());
                    m_cnt = m_cnt + 1'b1;
                end
                if (bus.inst_valid_i && rdy) q.push_back(model_decode(bus.inst_i));
            end
        end
        @(posedge clk);
        #1;
        if (rst_n) m_active = 1'b1;
    endtask

    task automatic test_reset();
        apply(1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.out_valid_o); end
        n_cmp++; if (bus.inst_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", bus.inst_ready_o); end
        n_cmp++; if (bus.dec_count_o !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.dec_count_o); end
        n_cmp++; if (dut_vec !== '0) begin n_fail++; $display("FAIL reset_fields got %h want 0", dut_vec); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_active = 1'b1;
        n_cmp++; if (bus.inst_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b want 1", bus.inst_ready_o); end
    endtask

    task automatic test_add();
        logic [31:0] a;
        logic [CNT_W-1:0] c0;
        c0 = m_cnt;
        a = mk(OP_ADD, 1'b0, {5'd3, 5'd4, 5'd5, 3'b101});
        apply(1'b1, a, 1'b1, 1'b0);
        n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL add_no_bypass got %b want 0", bus.out_valid_o); end
        advance();
        apply(1'b0, 32'h0, 1'b1, 1'b0);
        n_cmp++; if (bus.out_valid_o !== 1'b1) begin n_fail++; $display("FAIL add_valid got %b want 1", bus.out_valid_o); end
        n_cmp++; if ({bus.reg_addr_1_o, bus.reg_addr_2_o, bus.reg_addr_3_o, bus.reg_addr_4_o} !== {5'd3, 5'd4, 5'd5, 5'd0})
            begin n_fail++; $display("FAIL add_regs got %0d/%0d/%0d/%0d want 3/4/5/0", bus.reg_addr_1_o, bus.reg_addr_2_o, bus.reg_addr_3_o, bus.reg_addr_4_o); end
        n_cmp++; if (bus.illegal_o !== 1'b0) begin n_fail++; $display("FAIL add_illegal got %b want 0", bus.illegal_o); end
        advance();
        n_cmp++; if (bus.dec_count_o !== c0 + 1'b1) begin n_fail++; $display("FAIL add_count got %0d want %0d", bus.dec_count_o, c0 + 1'b1); end
        n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL add_drained got %b want 0", bus.out_valid_o); end
    endtask

    task automatic test_movein();
        apply(1'b1, mk(OP_MOVEIN, 1'b1, {16'hA5C3, 2'b00}), 1'b1, 1'b0);
        advance();
        apply(1'b0, 32'h0, 1'b1, 1'b0);
        n_cmp++; if (bus.ram_addr_o !== 16'hA5C3) begin n_fail++; $display("FAIL movein_ram got %h want a5c3", bus.ram_addr_o); end
        n_cmp++; if ({bus.imm_data_1_o, bus.imm_data_2_o} !== 16'hA5C3) begin n_fail++; $display("FAIL movein_imm got %h/%h want a5/c3", bus.imm_data_1_o, bus.imm_data_2_o); end
        n_cmp++; if ({bus.reg_addr_1_o, bus.reg_addr_2_o, bus.reg_addr_3_o, bus.reg_addr_4_o} !== '0) begin n_fail++; $display("FAIL movein_regs got nonzero want 0"); end
        advance();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, c;
        logic [CNT_W-1:0] c0;
        c0 = m_cnt;
        a = mk(OP_SUB, 1'b0, 18'($urandom));
        b = mk(OP_OR, 1'b1, 18'($urandom));
        c = mk(OP_MTHAN, 1'b0, 18'($urandom));
        apply(1'b1, a, 1'b0, 1'b0);
        advance();
        apply(1'b1, b, 1'b0, 1'b0);
        advance();
        apply(1'b1, c, 1'b0, 1'b0);
        n_cmp++; if (bus.inst_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %b want 0", bus.inst_ready_o); end
        n_cmp++; if (dut_vec !== model_decode(a)) begin n_fail++; $display("FAIL bp_head got %h want %h", dut_vec, model_decode(a)); end
        advance();
        apply(1'b1, c, 1'b1, 1'b0);
        n_cmp++; if (dut_vec !== model_decode(a)) begin n_fail++; $display("FAIL bp_hold got %h want %h", dut_vec, model_decode(a)); end
        n_cmp++; if (bus.inst_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_pop_ready got %b want 1", bus.inst_ready_o); end
        advance();
        apply(1'b0, 32'h0, 1'b1, 1'b0);
        n_cmp++; if (dut_vec !== model_decode(b)) begin n_fail++; $display("FAIL bp_second got %h want %h", dut_vec, model_decode(b)); end
        advance();
        n_cmp++; if (dut_vec !== model_decode(c) || bus.out_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_third got %h want %h", dut_vec, model_decode(c)); end
        advance();
        n_cmp++; if (bus.out_valid_o !== 1'b0 || bus.dec_count_o !== c0 + 16'd3) begin n_fail++; $display("FAIL bp_count got %0d valid %b want %0d valid 0", bus.dec_count_o, bus.out_valid_o, c0 + 16'd3); end
    endtask

    task automatic test_special_regs();
        apply(1'b1, mk(OP_DIV, 1'b0, 18'($urandom)), 1'b1, 1'b0);
        advance();
        apply(1'b1, mk(OP_EJUMP, 1'b0, 18'($urandom)), 1'b1, 1'b0);
        n_cmp++; if ({bus.reg_addr_3_o, bus.reg_addr_4_o, bus.illegal_o} !== {REG_MD_H, REG_MD_L, 1'b0})
            begin n_fail++; $display("FAIL div_regs got %0d/%0d want 30/29", bus.reg_addr_3_o, bus.reg_addr_4_o); end
        advance();
        apply(1'b1, mk(OP_MUL, 1'b1, 18'h3FFFF), 1'b1, 1'b0);
        n_cmp++; if ({bus.reg_addr_3_o, bus.reg_addr_4_o} !== {REG_JUMP_H, REG_JUMP_L})
            begin n_fail++; $display("FAIL ejump_regs got %0d/%0d want 28/27", bus.reg_addr_3_o, bus.reg_addr_4_o); end
        advance();
        apply(1'b0, 32'h0, 1'b1, 1'b0);
        n_cmp++; if (bus.illegal_o !== 1'b1 || bus.alu_o !== OP_MUL) begin n_fail++; $display("FAIL mul_imm_illegal got ill %b alu %0d want 1/3", bus.illegal_o, bus.alu_o); end
        n_cmp++; if ({bus.reg_addr_1_o, bus.reg_addr_2_o, bus.reg_addr_3_o, bus.reg_addr_4_o,
                      bus.ram_addr_o, bus.imm_data_1_o, bus.imm_data_2_o} !== '0)
            begin n_fail++; $display("FAIL mul_imm_fields got nonzero want 0"); end
        advance();
    endtask

    task automatic test_flush();
        logic [CNT_W-1:0] c0;
        apply(1'b1, mk(OP_AND, 1'b0, 18'($urandom)), 1'b0, 1'b0);
        advance();
        apply(1'b1, mk(OP_NOT, 1'b1, 18'($urandom)), 1'b0, 1'b0);
        advance();
        c0 = m_cnt;
        apply(1'b1, mk(OP_JUMP, 1'b0, 18'($urandom)), 1'b1, 1'b1);
        advance();
        apply(1'b0, 32'h0, 1'b1, 1'b0);
        n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", bus.out_valid_o); end
        n_cmp++; if (bus.dec_count_o !== c0) begin n_fail++; $display("FAIL flush_count got %0d want %0d", bus.dec_count_o, c0); end
        n_cmp++; if (dut_vec !== '0) begin n_fail++; $display("FAIL flush_fields got %h want 0", dut_vec); end
        advance();
    endtask

    task automatic test_random();
        logic [31:0] in;
        for (int i = 0; i < 400; i++) begin
            in = $urandom;
            in[31:24] = 8'($urandom_range(0, 19));
            apply(1'($urandom), in, 1'($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
            n_cmp++; if (bus.inst_ready_o !== model_ready()) begin n_fail++; $display("FAIL rand_ready cyc %0d got %b want %b", i, bus.inst_ready_o, model_ready()); end
            n_cmp++; if (bus.out_valid_o !== (q.size() > 0)) begin n_fail++; $display("FAIL rand_valid cyc %0d got %b want %b", i, bus.out_valid_o, q.size() > 0); end
            n_cmp++; if (dut_vec !== model_head()) begin n_fail++; $display("FAIL rand_fields cyc %0d got %h want %h", i, dut_vec, model_head()); end
            n_cmp++; if (bus.dec_count_o !== m_cnt) begin n_fail++; $display("FAIL rand_count cyc %0d got %0d want %0d", i, bus.dec_count_o, m_cnt); end
            advance();
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] c;
        apply(1'b1, mk(OP_ADD, 1'b0, 18'($urandom)), 1'b0, 1'b0);
        advance();
        apply(1'b1, mk(OP_MOVE, 1'b1, 18'($urandom)), 1'b0, 1'b0);
        advance();
        apply(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        q.delete();
        m_cnt = '0;
        m_active = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid_o !== 1'b0 || bus.inst_ready_o !== 1'b0) begin n_fail++; $display("FAIL arst_hs got v%b r%b want 0/0", bus.out_valid_o, bus.inst_ready_o); end
        n_cmp++; if (dut_vec !== '0 || bus.dec_count_o !== '0) begin n_fail++; $display("FAIL arst_out got %h cnt %0d want 0", dut_vec, bus.dec_count_o); end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_active = 1'b1;
        c = mk(OP_MOVEOUT, 1'b0, 18'($urandom));
        apply(1'b1, c, 1'b0, 1'b0);
        n_cmp++; if (bus.inst_ready_o !== 1'b1 || bus.dec_count_o !== '0) begin n_fail++; $display("FAIL arst_after got r%b cnt %0d want 1/0", bus.inst_ready_o, bus.dec_count_o); end
        advance();
        apply(1'b0, 32'h0, 1'b1, 1'b0);
        n_cmp++; if (dut_vec !== model_decode(c) || bus.out_valid_o !== 1'b1) begin n_fail++; $display("FAIL arst_first got %h want %h", dut_vec, model_decode(c)); end
        advance();
        n_cmp++; if (bus.dec_count_o !== 16'd1) begin n_fail++; $display("FAIL arst_count got %0d want 1", bus.dec_count_o); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_movein();
        test_back_to_back();
        test_special_regs();
        test_flush();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
